axil_cmd_master: RTL

//  AXI4-Lite master that turns a simple command/response stream into protocol-clean AXI-Lite

---
 rtl/axil_pkg.sv | 26 ++
 rtl/axil_wait_ctr.sv | 43 ++++
 rtl/axil_cmd_master.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
`timescale 1ns/1ps
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // States in which the master is waiting on the slave and the stall counter runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_REQ) || (s == ST_RD_RESP);
  endfunction

endpackage

// File: rtl/axil_wait_ctr.sv
// Saturating stall counter with a sticky error flag that sets when the count reaches MAX_WAIT.
`timescale 1ns/1ps
module axil_wait_ctr #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != CNT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Sticky: only reset clears it; the transaction itself keeps running.
    if (cnt_d == CNT_W'(MAX_WAIT)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: converts a command/response stream into single outstanding AXI-Lite
// read or write transactions, with a sticky stall monitor on every wait phase.
`timescale 1ns/1ps
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MAX_WAIT           = 15
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic                              i_cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   i_cmd_wstrb,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic                              o_rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic [1:0]                        o_rsp_resp,
  output logic                              o_stall_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  logic            wait_clr;
  logic            wait_inc;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          addr_d = i_cmd_addr;
          if (i_cmd_write) begin
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W channels complete independently, in either order.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          state_d     = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI_RESP_OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Any state change restarts the count, so each wait phase is timed on its own.
  assign wait_clr = (state_d != state_q);
  assign wait_inc = is_wait_state(state_q) && !wait_clr;

  axil_wait_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (4)
  ) u_wait_ctr (
    .clk   (M_AXI_ACLK),
    .rst_n (M_AXI_ARESETN),
    .i_clr (wait_clr),
    .i_inc (wait_inc),
    .o_err (o_stall_err)
  );

  assign o_cmd_ready   = (state_q == ST_IDLE);
  assign o_rsp_valid   = (state_q == ST_RSP);
  assign o_rsp_write   = rsp_write_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_resp    = rsp_resp_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == ST_RD_RESP);

endmodule
